// File: rtl/generic_hdr_demux.sv
// Header-steered demultiplexer: one header + AXI-Stream payload frame is routed to the output
// port named by a header bit field; frames with an out-of-range index are consumed and counted.
//
// state | meaning
// IDLE  | waiting for a header; payload input held off
// FWD   | forwarding payload beats to the latched port through a two-register skid buffer
// DROP  | consuming payload beats of an out-of-range frame
module generic_hdr_demux #(
   parameter int M_COUNT      = 4,
   parameter int DATA_WIDTH   = 64,
   parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter bit USER_ENABLE  = 1,
   parameter int USER_WIDTH   = 1,
   parameter int HEADER_WIDTH = 12,
   parameter int SEL_OFFSET   = 0,
   parameter int SEL_WIDTH    = $clog2(M_COUNT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_hdr_valid,
   output logic                      s_hdr_ready,
   input  logic [HEADER_WIDTH*8-1:0] s_hdr,
   input  logic [DATA_WIDTH-1:0]     s_payload_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]     s_payload_axis_tkeep,
   input  logic                      s_payload_axis_tvalid,
   output logic                      s_payload_axis_tready,
   input  logic                      s_payload_axis_tlast,
   input  logic [USER_WIDTH-1:0]     s_payload_axis_tuser,
   output logic [M_COUNT-1:0]        m_hdr_valid,
   input  logic [M_COUNT-1:0]        m_hdr_ready,
   output logic [HEADER_WIDTH*8-1:0] m_hdr,
   output logic [DATA_WIDTH-1:0]     m_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]     m_payload_axis_tkeep,
   output logic [M_COUNT-1:0]        m_payload_axis_tvalid,
   input  logic [M_COUNT-1:0]        m_payload_axis_tready,
   output logic                      m_payload_axis_tlast,
   output logic [USER_WIDTH-1:0]     m_payload_axis_tuser,
   output logic [15:0]               drop_count,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t                    state_q, state_d;
   logic [SEL_WIDTH-1:0]      sel_q, sel_d, s_sel;
   logic [M_COUNT-1:0]        hdr_valid_q, hdr_valid_d;
   logic [HEADER_WIDTH*8-1:0] hdr_q;
   logic [15:0]               drop_q, drop_d;
   logic                      ready_q, ready_d;
   logic                      out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
   logic [DATA_WIDTH-1:0]     out_data_q, tmp_data_q;
   logic [KEEP_WIDTH-1:0]     out_keep_q, tmp_keep_q;
   logic                      out_last_q, tmp_last_q;
   logic [USER_WIDTH-1:0]     out_user_q, tmp_user_q;
   logic                      hdr_load, hdr_fire, pay_fire, in_range, hdr_free, pay_empty, m_ready_sel;
   logic                      store_in_out, store_in_tmp, store_tmp_out;

   always_comb begin
      s_sel       = s_hdr[SEL_OFFSET +: SEL_WIDTH];
      in_range    = 32'(s_sel) < M_COUNT;
      hdr_free    = ~|(hdr_valid_q & ~m_hdr_ready);
      pay_empty   = !out_valid_q && !tmp_valid_q;
      m_ready_sel = 1'b0;
      for (int i = 0; i < M_COUNT; i++) begin
         if (sel_q == SEL_WIDTH'(i)) m_ready_sel = m_payload_axis_tready[i];
      end
      // A different port may only be selected once the skid buffer has drained to the old one.
      s_hdr_ready = !rst && (state_q == IDLE) && hdr_free && ((s_sel == sel_q) || pay_empty);
      s_payload_axis_tready = !rst && (((state_q == FWD) && ready_q) || (state_q == DROP));
      hdr_fire = s_hdr_valid && s_hdr_ready;
      pay_fire = s_payload_axis_tvalid && s_payload_axis_tready;

      state_d     = state_q;
      sel_d       = sel_q;
      drop_d      = drop_q;
      hdr_load    = 1'b0;
      hdr_valid_d = hdr_valid_q & ~m_hdr_ready;
      case (state_q)
         IDLE: begin
            if (hdr_fire) begin
               if (in_range) begin
                  state_d  = FWD;
                  sel_d    = s_sel;
                  hdr_load = 1'b1;
                  for (int i = 0; i < M_COUNT; i++) begin
                     if (s_sel == SEL_WIDTH'(i)) hdr_valid_d[i] = 1'b1;
                  end
               end else begin
                  state_d = DROP;
               end
            end
         end
         FWD: begin
            if (pay_fire && s_payload_axis_tlast) state_d = IDLE;
         end
         DROP: begin
            if (pay_fire && s_payload_axis_tlast) begin
               drop_d  = drop_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d       = m_ready_sel || pay_empty;
      out_valid_d   = out_valid_q;
      tmp_valid_d   = tmp_valid_q;
      store_in_out  = 1'b0;
      store_in_tmp  = 1'b0;
      store_tmp_out = 1'b0;
      if ((state_q == FWD) && ready_q) begin
         if (m_ready_sel || !out_valid_q) begin
            out_valid_d  = s_payload_axis_tvalid;
            store_in_out = 1'b1;
         end else begin
            tmp_valid_d  = s_payload_axis_tvalid;
            store_in_tmp = 1'b1;
         end
      end else if (m_ready_sel) begin
         out_valid_d   = tmp_valid_q;
         tmp_valid_d   = 1'b0;
         store_tmp_out = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         hdr_valid_q <= '0;
         drop_q      <= '0;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         tmp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         hdr_valid_q <= hdr_valid_d;
         drop_q      <= drop_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         tmp_valid_q <= tmp_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hdr_load) hdr_q <= s_hdr;
      if (store_in_out) begin
         out_data_q <= s_payload_axis_tdata;
         out_keep_q <= s_payload_axis_tkeep;
         out_last_q <= s_payload_axis_tlast;
         out_user_q <= s_payload_axis_tuser;
      end else if (store_tmp_out) begin
         out_data_q <= tmp_data_q;
         out_keep_q <= tmp_keep_q;
         out_last_q <= tmp_last_q;
         out_user_q <= tmp_user_q;
      end
      if (store_in_tmp) begin
         tmp_data_q <= s_payload_axis_tdata;
         tmp_keep_q <= s_payload_axis_tkeep;
         tmp_last_q <= s_payload_axis_tlast;
         tmp_user_q <= s_payload_axis_tuser;
      end
   end

   always_comb begin
      for (int i = 0; i < M_COUNT; i++) begin
         m_payload_axis_tvalid[i] = out_valid_q && (sel_q == SEL_WIDTH'(i));
      end
   end

   assign m_hdr_valid          = hdr_valid_q;
   assign m_hdr                = hdr_q;
   assign m_payload_axis_tdata = out_data_q;
   assign m_payload_axis_tkeep = KEEP_ENABLE ? out_keep_q : '1;
   assign m_payload_axis_tlast = out_last_q;
   assign m_payload_axis_tuser = USER_ENABLE ? out_user_q : '0;
   assign drop_count           = drop_q;
   assign busy                 = (state_q != IDLE);

endmodule
